sdram_burst_reader: RTL and testbench
=====================================

// Module: sdram_burst_reader
// PURPOSE
//  Avalon-MM burst read master driving the fabric's 256-bit SDRAM read port (sdram0_data).
//  Takes a (word address, beat count) command and splits it into aligned bursts.
//  Issues a burst only when the local FIFO can absorb every beat of it.
//  Returns the data as a valid/ready stream to the accelerator datapath, with the final beat tagged.
// PARAMETERS
//  ADDR_W      27   Avalon word-address width (one word = one DATA_W beat)
//  DATA_W      256  beat width
//  BURST_W     8    burstcount width
//  MAX_BURST   16   max beats per burst; power of 2, <= 2**(BURST_W-1)
//  FIFO_DEPTH  64   return FIFO entries; power of 2, >= 2*MAX_BURST
//  LEN_W       24   command length width (beats)
// PORTS
//  clk             in   1        system clock (clock_95 domain)
//  reset           in   1        async, active-high
//  cmd_valid       in   1        command request
//  cmd_ready       out  1        high only in IDLE
//  cmd_addr        in   ADDR_W   start word address
//  cmd_len         in   LEN_W    beats to read
//  busy            out  1        command in progress
//  done            out  1        1-cycle pulse: command complete
//  avm_address     out  ADDR_W   to sdram0_data_address
//  avm_burstcount  out  BURST_W  to sdram0_data_burstcount
//  avm_read        out  1        to sdram0_data_read
//  avm_waitrequest in   1        from sdram0_data_waitrequest
//  avm_readdata    in   DATA_W   from sdram0_data_readdata
//  avm_readdatavalid in 1        from sdram0_data_readdatavalid
//  out_valid       out  1        stream beat valid
//  out_ready       in   1        stream consumer ready
//  out_data        out  DATA_W   beat data
//  out_last        out  1        final beat of command
// BEHAVIOUR
//  Reset values: cmd_ready=1; busy=0, done=0, avm_read=0, avm_address=0, avm_burstcount=0, out_valid=0, out_last=0.
//   FIFO empty; outstanding=0.
//  FSM IDLE:
//   - cmd_valid&cmd_ready latches addr/len.
//   - len==0: done pulses next cycle, stay IDLE.
//   - Otherwise go to ISSUE.
//  FSM ISSUE:
//   - Burst size: bl = min(remaining, MAX_BURST - (addr % MAX_BURST)). A burst never crosses a MAX_BURST boundary.
//   - Assert avm_read only when (FIFO_DEPTH - fifo_count - outstanding) >= bl.
//   - While avm_waitrequest=1: avm_read, avm_address and avm_burstcount stay stable.
//   - Burst accepted (avm_read & !avm_waitrequest): addr += bl, remaining -= bl, outstanding += bl. Next burst may issue the following cycle.
//   - remaining reaches 0 on acceptance: deassert avm_read and go to DRAIN.
//  FSM DRAIN: wait until the last-tagged beat is popped (out_valid&out_ready&out_last). Then done=1 for one cycle and go to IDLE.
//  Return path:
//   - Every avm_readdatavalid beat is written to the FIFO with outstanding -= 1. Credit check guarantees no overflow.
//   - Beat accepted and a beat returned in the same cycle: outstanding += bl - 1.
//   - The beat that brings the command's returned count to cmd_len is stored with last=1.
//  Stream:
//   - out_valid = FIFO non-empty; show-ahead, so out_data is valid combinationally with out_valid.
//   - Simultaneous push and pop on a full FIFO is legal; count is unchanged.
//  busy = state != IDLE.
//  Latency: first avm_read is asserted 1 cycle after command acceptance.
//  Reset mid-operation: all state clears immediately.
//   - reset shares its source with the SDRAM bridge reset.
//   - avm_readdatavalid beats seen while outstanding==0 are dropped.
// CONFIGURATION
//  SDRAM_RD_PERF_EN defined:
//   - Adds out ports perf_beats[31:0] (beats returned) and perf_stall[31:0] (cycles with avm_read & avm_waitrequest).
//   - Both are cleared on command acceptance and saturate at 2**32-1.
//  Not defined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  1. addr=0x100, len=32, zero-wait slave, out_ready=1 -> two bursts (16,16) at 0x100/0x110; 32 beats in order; out_last on beat 32; done once.
//  2. addr=0x10D, len=20 -> bursts 3@0x10D, 16@0x110, 1@0x120; burstcount never 0 and never >16.
//  3. out_ready=0, len=200 -> avm_read stops after fifo_count+outstanding=64; no overflow; resumes when out_ready=1; 200 beats total.
//  4. waitrequest held 5 cycles on burst 1 -> address/burstcount stable throughout; with SDRAM_RD_PERF_EN, perf_stall=5.
//  5. len=0 -> no avm_read; done pulses 1 cycle after acceptance.
//  6. reset asserted mid-burst with 7 beats outstanding -> outputs return to reset values at once; late beats dropped; next command correct.

Source files
------------

// File: rtl/sdram_burst_reader.sv
// sdram_burst_reader: Avalon-MM burst read master that splits a command into aligned, credit-checked bursts.
// Optional SDRAM_RD_PERF_EN adds perf_beats/perf_stall counters.
module sdram_burst_reader #(
  parameter int ADDR_W     = 27,
  parameter int DATA_W     = 256,
  parameter int BURST_W    = 8,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64,
  parameter int LEN_W      = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [LEN_W-1:0]   cmd_len,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  avm_address,
  output logic [BURST_W-1:0] avm_burstcount,
  output logic               avm_read,
  input  logic               avm_waitrequest,
  input  logic [DATA_W-1:0]  avm_readdata,
  input  logic               avm_readdatavalid,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last
`ifdef SDRAM_RD_PERF_EN
  ,
  output logic [31:0]        perf_beats,
  output logic [31:0]        perf_stall
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = $clog2(MAX_BURST);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d, ret_q, ret_d;
  logic [CW-1:0] outs_q, outs_d, cnt_q, cnt_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic done_q, done_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_q;
  logic [BURST_W-1:0] space, bl;
  logic [CW:0] used;
  logic accept, push, pop, cmd_acc;
  always_comb begin
    space = BURST_W'(MAX_BURST) - BURST_W'(addr_q[MW-1:0]);
    bl = (rem_q < LEN_W'(space)) ? BURST_W'(rem_q) : space;
    used = {1'b0, cnt_q} + {1'b0, outs_q};
    cmd_ready = state_q == IDLE;
    busy = !cmd_ready;
    done = done_q;
    cmd_acc = cmd_valid && cmd_ready;
    // Credit only ever grows while a burst waits, so this read stays asserted until accepted.
    avm_read = (state_q == ISSUE) && (FIFO_DEPTH - int'(used) >= int'(bl));
    avm_address = addr_q;
    avm_burstcount = bl;
    accept = avm_read && !avm_waitrequest;
    push = avm_readdatavalid && (outs_q != '0);
    out_valid = cnt_q != '0;
    pop = out_valid && out_ready;
    out_data = mem_q[rd_q];
    out_last = out_valid && last_q[rd_q];
    outs_d = outs_q + (accept ? CW'(bl) : CW'(0)) - CW'(push);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    wr_d = wr_q + PW'(push);
    rd_d = rd_q + PW'(pop);
    ret_d = ret_q - LEN_W'(push);
    state_d = state_q;
    addr_d = addr_q;
    rem_d = rem_q;
    done_d = 1'b0;
    if (cmd_acc) begin
      addr_d = cmd_addr;
      rem_d = cmd_len;
      ret_d = cmd_len;
      done_d = cmd_len == '0;
      state_d = (cmd_len == '0) ? IDLE : ISSUE;
    end
    if (accept) begin
      addr_d = addr_q + ADDR_W'(bl);
      rem_d = rem_q - LEN_W'(bl);
      state_d = (rem_q == LEN_W'(bl)) ? DRAIN : ISSUE;
    end
    if (state_q == DRAIN && pop && out_last) begin
      done_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      rem_q <= '0;
      ret_q <= '0;
      outs_q <= '0;
      cnt_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      rem_q <= rem_d;
      ret_q <= ret_d;
      outs_q <= outs_d;
      cnt_q <= cnt_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= avm_readdata;
      last_q[wr_q] <= ret_q == LEN_W'(1);
    end
  end
`ifdef SDRAM_RD_PERF_EN
  logic [31:0] beats_q, beats_d, stall_q, stall_d;
  always_comb begin
    beats_d = cmd_acc ? 32'd0 : beats_q + 32'(push && !(&beats_q));
    stall_d = cmd_acc ? 32'd0 : stall_q + 32'(avm_read && avm_waitrequest && !(&stall_q));
    perf_beats = beats_q;
    perf_stall = stall_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_burst_reader.sv
// tb_sdram_burst_reader: table, hand-written and random commands against a burst/beat reference model
module tb_sdram_burst_reader;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid, cmd_ready, busy, done, avm_read, avm_waitrequest, avm_readdatavalid;
  logic out_valid, out_ready, out_last;
  logic [26:0] cmd_addr, avm_address;
  logic [23:0] cmd_len;
  logic [7:0] avm_burstcount;
  logic [255:0] avm_readdata, out_data;
`ifdef SDRAM_RD_PERF_EN
  logic [31:0] perf_beats, perf_stall;
`endif
  sdram_burst_reader dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .busy(busy), .done(done),
    .avm_address(avm_address), .avm_burstcount(avm_burstcount), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
`ifdef SDRAM_RD_PERF_EN
    , .perf_beats(perf_beats), .perf_stall(perf_stall)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {logic [26:0] a; int bc;} burst_t;
  typedef struct {logic [255:0] d; logic l;} beat_t;
  typedef struct {logic [26:0] a; int rc;} sbeat_t;
  typedef struct {logic [26:0] addr; int len; int rdy; int ws; int nb; int fb;} vec_t;
  burst_t exp_b[$];
  beat_t exp_d[$];
  sbeat_t sq[$];
  burst_t mb;
  beat_t mbeat;
  int nchk = 0, nfail = 0;
  int cyc = 0, m_out = 0, m_fifo = 0, viol = 0, nbursts = 0, first_bc = 0, done_cnt = 0;
  int rdy_pct = 100, rv_pct = 100, lat_max = 2, ws_lo = 0, ws_hi = 0, wait_left = 0;
  logic prev_stall = 1'b0;
  logic [26:0] p_addr;
  logic [7:0] p_bc;
  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [255:0] dat(input logic [26:0] a);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32+:32] = ({5'(i), a} * 32'h9E3779B1) ^ 32'h5A5A0000;
    return d;
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // Slave and consumer drive their inputs just after each rising edge.
  always @(posedge clk) begin
    #1;
    out_ready = $urandom_range(0, 99) < rdy_pct;
    avm_readdatavalid = 1'b0;
    if (sq.size() > 0 && sq[0].rc <= cyc && $urandom_range(0, 99) < rv_pct) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = dat(sq[0].a);
      void'(sq.pop_front());
    end
    avm_waitrequest = 1'b0;
    if (avm_read && wait_left > 0) begin
      avm_waitrequest = 1'b1;
      wait_left--;
    end
  end
  always @(negedge clk) begin
    if (reset) prev_stall = 1'b0;
    else begin
      if (prev_stall && !(avm_read && avm_address == p_addr && avm_burstcount == p_bc)) viol++;
      if (avm_read && (avm_burstcount == 0 || avm_burstcount > 16 || m_out + m_fifo + int'(avm_burstcount) > 64)) viol++;
      prev_stall = avm_read && avm_waitrequest;
      p_addr = avm_address;
      p_bc = avm_burstcount;
      if (done) done_cnt++;
      if (avm_read && !avm_waitrequest) begin
        nbursts++;
        if (nbursts == 1) first_bc = int'(avm_burstcount);
        chk("burst_expected", 256'(exp_b.size() > 0), 1);
        if (exp_b.size() > 0) begin
          mb = exp_b.pop_front();
          chk("burst_addr", avm_address, mb.a);
          chk("burst_cnt", avm_burstcount, mb.bc);
        end
        for (int i = 0; i < int'(avm_burstcount); i++)
          sq.push_back('{avm_address + 27'(i), cyc + 1 + int'($urandom_range(0, lat_max))});
        m_out += int'(avm_burstcount);
        wait_left = $urandom_range(ws_lo, ws_hi);
      end
      if (avm_readdatavalid && m_out > 0) begin
        m_out--;
        m_fifo++;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", 256'(exp_d.size() > 0), 1);
        if (exp_d.size() > 0) begin
          mbeat = exp_d.pop_front();
          chk("beat_data", out_data, mbeat.d);
          chk("beat_last", out_last, mbeat.l);
        end
        m_fifo--;
      end
    end
  end
  task automatic chk_reset_vals(input string nm);
    chk(nm, {cmd_ready, busy, done, avm_read, avm_address, avm_burstcount, out_valid, out_last},
        {1'b1, 3'b000, 27'd0, 8'd0, 2'b00});
  endtask
  task automatic start_cmd(input logic [26:0] a, input int len, output int nb, output int fb);
    logic [26:0] ca;
    int r;
    ca = a;
    r = len;
    nb = 0;
    fb = 0;
    exp_b.delete();
    exp_d.delete();
    nbursts = 0;
    first_bc = 0;
    done_cnt = 0;
    viol = 0;
    while (r > 0) begin
      int sp, b;
      sp = 16 - int'(ca % 16);
      b = r < sp ? r : sp;
      exp_b.push_back('{ca, b});
      if (nb == 0) fb = b;
      nb++;
      ca += 27'(b);
      r -= b;
    end
    for (int i = 0; i < len; i++) exp_d.push_back('{dat(a + 27'(i)), i == len - 1});
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = 24'(len);
    @(negedge clk);
    chk("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("first_read", {avm_read, busy, done}, {len != 0, len != 0, len == 0});
  endtask
  task automatic finish_cmd(input int exp_nb, input int exp_fb);
    int t;
    t = 0;
    while (done_cnt == 0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 256'(t < 4000), 1);
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt, 1);
    chk("burst_count", nbursts, exp_nb);
    chk("first_burst", first_bc, exp_fb);
    chk("beats_left", exp_d.size(), 0);
    chk("protocol_viol", viol, 0);
    chk("idle", {busy, cmd_ready, out_valid}, 3'b010);
  endtask
  initial begin
    vec_t tv[7];
    int nb, fb, t;
    tv[0] = '{27'h100, 32, 100, 0, 2, 16};
    tv[1] = '{27'h10D, 20, 100, 0, 3, 3};
    tv[2] = '{27'h000, 5, 60, 0, 1, 5};
    tv[3] = '{27'h03F, 1, 100, 0, 1, 1};
    tv[4] = '{27'h10F, 17, 50, 0, 2, 1};
    tv[5] = '{27'h100, 16, 100, 5, 1, 16};
    tv[6] = '{27'h200, 0, 100, 0, 0, 0};
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    out_ready = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata = '0;
    avm_readdatavalid = 1'b0;
    #1 chk_reset_vals("reset_state");
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rdy_pct = tv[i].rdy;
      rv_pct = 100;
      ws_lo = 0;
      ws_hi = 0;
      wait_left = tv[i].ws;
      start_cmd(tv[i].addr, tv[i].len, nb, fb);
      finish_cmd(tv[i].nb, tv[i].fb);
`ifdef SDRAM_RD_PERF_EN
      chk("perf_stall", perf_stall, tv[i].ws);
      chk("perf_beats", perf_beats, tv[i].len);
`endif
    end
    rdy_pct = 0;
    start_cmd(27'h400, 200, nb, fb);
    repeat (150) @(negedge clk);
    chk("credit_full", m_out + m_fifo, 64);
    chk("credit_stop", {avm_read, out_valid}, 2'b01);
    rdy_pct = 100;
    finish_cmd(13, 16);
    rv_pct = 0;
    ws_lo = 50;
    ws_hi = 50;
    wait_left = 0;
    start_cmd(27'h009, 64, nb, fb);
    t = 0;
    while (m_out != 7 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("seven_outstanding", m_out, 7);
    #2 reset = 1'b1;
    #1 chk_reset_vals("reset_mid");
    exp_b.delete();
    exp_d.delete();
    m_out = 0;
    m_fifo = 0;
    wait_left = 0;
    ws_lo = 0;
    ws_hi = 0;
    rv_pct = 100;
    rdy_pct = 100;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("late_beats_dropped", {out_valid, busy, cmd_ready}, 3'b001);
    start_cmd(27'h009, 20, nb, fb);
    finish_cmd(2, 7);
    for (int k = 0; k < 20; k++) begin
      rdy_pct = $urandom_range(20, 100);
      rv_pct = $urandom_range(30, 100);
      ws_lo = 0;
      ws_hi = $urandom_range(0, 3);
      lat_max = 3;
      wait_left = 0;
      start_cmd(27'($urandom_range(0, 27'h7FFFF)), $urandom_range(1, 100), nb, fb);
      finish_cmd(nb, fb);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
